// File: rtl/fp_l2_sq_accum_pkg.sv
// Shared FP constants, FSM state encodings and helpers for the L2 accumulator and sqrt unit.
package fp_l2_sq_accum_pkg;
    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
    localparam logic [31:0] FP_PINF    = 32'h7F800000;
    localparam logic [31:0] FP_ZERO    = 32'h00000000;
    localparam logic [1:0]  RM_NEAREST = 2'b00;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic fp_is_nan_inf(input logic [31:0] x);
        return x[30:23] == 8'hFF;
    endfunction
endpackage

// File: rtl/FpAdder.sv
// Combinational binary32 adder; denormals flush to zero, round_mode 00 = nearest-even, else truncate.
module FpAdder
    import fp_l2_sq_accum_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  round_mode,
    output logic [31:0] y
);
    logic              a_nan, b_nan, a_inf, b_inf, swap, sl, ss, lost, rnd_up;
    logic [7:0]        el, es, sh;
    logic [23:0]       ml, ms;
    logic [26:0]       ms_sh;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic [24:0]       mant_r;
    logic signed [9:0] ex;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd0;
        for (int i = 0; i < 27; i++)
            if (v[i]) lzc27 = 5'(26 - i);
    endfunction

    always_comb begin
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != '0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != '0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == '0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == '0);
        swap  = b[30:0] > a[30:0];
        sl    = swap ? b[31] : a[31];
        ss    = swap ? a[31] : b[31];
        el    = swap ? b[30:23] : a[30:23];
        es    = swap ? a[30:23] : b[30:23];
        ml    = (el == '0) ? '0 : {1'b1, swap ? b[22:0] : a[22:0]};
        ms    = (es == '0) ? '0 : {1'b1, swap ? a[22:0] : b[22:0]};
        sh    = el - es;
        lost  = 1'b0;
        // Three extra bits below the mantissa act as guard, round and sticky.
        if (sh >= 8'd27) begin
            ms_sh = {26'b0, |ms};
        end else begin
            ms_sh    = {ms, 3'b000} >> sh;
            lost     = |({ms, 3'b000} << (8'd27 - sh));
            ms_sh[0] = ms_sh[0] | lost;
        end
        sum = (sl ^ ss) ? ({1'b0, ml, 3'b000} - {1'b0, ms_sh})
                        : ({1'b0, ml, 3'b000} + {1'b0, ms_sh});
        ex  = $signed({2'b00, el});
        lz  = '0;
        if (sum[27]) begin
            sum = {1'b0, sum[27:2], sum[1] | sum[0]};
            ex  = ex + 10'sd1;
        end else begin
            lz  = lzc27(sum[26:0]);
            sum = sum << lz;
            ex  = ex - $signed({5'b0, lz});
        end
        rnd_up = (round_mode == RM_NEAREST) && sum[2] && (sum[1] || sum[0] || sum[3]);
        mant_r = {1'b0, sum[26:3]} + {24'b0, rnd_up};
        if (mant_r[24]) ex = ex + 10'sd1;

        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) y = FP_QNAN;
        else if (a_inf)                  y = a;
        else if (b_inf)                  y = b;
        else if (sum[26:0] == '0)        y = FP_ZERO;
        else if (ex >= 10'sd255)         y = {sl, FP_PINF[30:0]};
        else if (ex <= 10'sd0)           y = {sl, 31'b0};
        else y = {sl, ex[7:0], (mant_r[24] ? mant_r[23:1] : mant_r[22:0])};
    end
endmodule

// File: rtl/FpMul.sv
// Combinational binary32 multiplier; denormals flush to zero, round_mode 00 = nearest-even, else truncate.
module FpMul
    import fp_l2_sq_accum_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  round_mode,
    output logic [31:0] y
);
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn, g, st, rnd_up;
    logic [47:0]       prod;
    logic [23:0]       mant;
    logic [24:0]       mant_r;
    logic signed [9:0] ex;

    always_comb begin
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != '0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != '0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == '0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == '0);
        a_zero = (a[30:23] == '0);
        b_zero = (b[30:23] == '0);
        sgn    = a[31] ^ b[31];
        prod   = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        ex     = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if (prod[47]) begin
            mant = prod[47:24];
            g    = prod[23];
            st   = |prod[22:0];
            ex   = ex + 10'sd1;
        end else begin
            mant = prod[46:23];
            g    = prod[22];
            st   = |prod[21:0];
        end
        rnd_up = (round_mode == RM_NEAREST) && g && (st || mant[0]);
        mant_r = {1'b0, mant} + {24'b0, rnd_up};
        if (mant_r[24]) ex = ex + 10'sd1;

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) y = FP_QNAN;
        else if (a_inf || b_inf)   y = {sgn, FP_PINF[30:0]};
        else if (a_zero || b_zero) y = {sgn, 31'b0};
        else if (ex >= 10'sd255)   y = {sgn, FP_PINF[30:0]};
        else if (ex <= 10'sd0)     y = {sgn, 31'b0};
        else y = {sgn, ex[7:0], (mant_r[24] ? mant_r[23:1] : mant_r[22:0])};
    end
endmodule

// File: rtl/fp_l2_sq_accum_sq_diff.sv
// Combinational (a - b)^2 stage built from the shared FP adder and multiplier.
module fp_sq_diff
    import fp_l2_sq_accum_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] q
);
    logic [31:0] b_neg, d;

    assign b_neg = {~b[31], b[30:0]};

    FpAdder u_sub (.a(a), .b(b_neg), .round_mode(RM_NEAREST), .y(d));
    FpMul   u_sq  (.a(d), .b(d),     .round_mode(RM_NEAREST), .y(q));
endmodule

// File: rtl/fp_l2_sq_accum.sv
// Streaming sum((a_i-b_i)^2) over VEC_LEN float pairs; result and pulse feed the sqrt unit.
module fp_l2_sq_accum
    import fp_l2_sq_accum_pkg::*;
#(
    parameter int D_Len   = 32,
    parameter int VEC_LEN = 128,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [D_Len-1:0] in_a,
    input  logic [D_Len-1:0] in_b,
    output logic [D_Len-1:0] sum_out,
    output logic             sum_valid,
    output logic             busy,
    output logic             nan_err
);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);
    localparam logic [D_Len-1:0] ABS_MASK = {1'b0, {(D_Len-1){1'b1}}};

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [D_Len-1:0] acc, sq_reg, q, acc_sum;
    logic             sq_vld, add_pend, xfer, in_nan;

    assign in_ready = (state == ST_ACCUM);
    assign busy     = (state != ST_IDLE);
    assign xfer     = in_valid & in_ready;
    assign in_nan   = fp_is_nan_inf(in_a) | fp_is_nan_inf(in_b) | fp_is_nan_inf(q);

    fp_sq_diff u_sq_diff (.a(in_a), .b(in_b), .q(q));
    FpAdder    u_acc_add (.a(acc), .b(sq_reg), .round_mode(RM_NEAREST), .y(acc_sum));

    // add_pend marks the cycle after an add, when the registered acc is checked for NaN/Inf
    // so the flag is settled before DRAIN hands the result out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            acc       <= FP_ZERO;
            sq_reg    <= FP_ZERO;
            sq_vld    <= 1'b0;
            add_pend  <= 1'b0;
            sum_out   <= FP_ZERO;
            sum_valid <= 1'b0;
            nan_err   <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            sq_vld    <= xfer;
            add_pend  <= sq_vld;
            if (xfer) begin
                sq_reg <= q;
                cnt    <= cnt + 1'b1;
                if (in_nan) nan_err <= 1'b1;
            end
            if (sq_vld) acc <= acc_sum & ABS_MASK;
            if (add_pend && fp_is_nan_inf(acc)) nan_err <= 1'b1;

            case (state)
                ST_IDLE: if (start) begin
                    acc     <= FP_ZERO;
                    cnt     <= '0;
                    nan_err <= 1'b0;
                    state   <= ST_ACCUM;
                end
                ST_ACCUM: if (xfer && cnt == LAST_IDX) state <= ST_DRAIN;
                ST_DRAIN: if (!sq_vld && !add_pend) begin
                    sum_out   <= nan_err ? FP_QNAN : acc;
                    sum_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_l2_sq_accum.sv
// Self-checking bench for fp_l2_sq_accum with VEC_LEN=4; expected sums come from exact integer arithmetic.
module tb_fp_l2_sq_accum;
    localparam int VLEN = 4;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic [31:0] in_a = '0, in_b = '0;
    logic        in_ready, sum_valid, busy, nan_err;
    logic [31:0] sum_out;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    fp_l2_sq_accum #(.D_Len(32), .VEC_LEN(VLEN), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .sum_out(sum_out), .sum_valid(sum_valid),
        .busy(busy), .nan_err(nan_err)
    );

    // Value n * 2^e2 as binary32 bits; exact for |n| < 2^24.
    function automatic logic [31:0] to_fp(input longint n, input int e2);
        logic   s;
        longint m;
        int     p;
        if (n == 0) return 32'h0;
        s = (n < 0);
        m = s ? -n : n;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        return {s, 8'(p + e2 + 127), 23'((m << (23 - p)) & 64'h7FFFFF)};
    endfunction

    function automatic logic [31:0] half(input int k);
        return to_fp(longint'(k), -1);
    endfunction

    // Elements are k/2; the squared distance is then an integer count of quarters.
    function automatic logic [31:0] model_sum(input int ka[VLEN], input int kb[VLEN]);
        longint s = 0;
        for (int i = 0; i < VLEN; i++) s += longint'((ka[i] - kb[i]) * (ka[i] - kb[i]));
        return to_fp(s, -2);
    endfunction

    task automatic pulse_start;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic feed(input logic [31:0] av[VLEN], input logic [31:0] bv[VLEN],
                        input int gap_mode, input int start_at, output bit stuck);
        int i = 0;
        int guard = 0;
        bit tog = 1'b1;
        bit st_done = 1'b0;
        while (i < VLEN && guard < 200) begin
            in_a = av[i];
            in_b = bv[i];
            case (gap_mode)
                0:       in_valid = 1'b1;
                1:       in_valid = tog;
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            tog = ~tog;
            if (i == start_at && !st_done) begin
                start   = 1'b1;
                st_done = 1'b1;
            end
            @(negedge clk);
            if (in_valid && in_ready) i++;
            @(posedge clk); #1;
            start = 1'b0;
            guard++;
        end
        in_valid = 1'b0;
        stuck = (i < VLEN);
    endtask

    // Returns at the negedge of the sum_valid cycle; lat counts edges after the last accept.
    task automatic wait_done(input bit drain_start, output int lat, output int extra, output bit timeout);
        lat = -1;
        extra = 0;
        timeout = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) extra++;
            if (sum_valid) begin
                lat = c;
                timeout = 1'b0;
                break;
            end
            if (drain_start && c == 1) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic test_reset;
        #12;
        n_cmp++; if (sum_out !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_sum_out: got %h expected %h", sum_out, 32'h0); end
        n_cmp++; if (sum_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_sum_valid: got %b expected 0", sum_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_cmp++; if (nan_err !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_nan_err: got %b expected 0", nan_err); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic [31:0] av[VLEN], bv[VLEN];
        int ka[VLEN] = '{2, 4, 6, 8};
        int lat, extra;
        bit stuck, to;
        for (int i = 0; i < VLEN; i++) begin av[i] = half(ka[i]); bv[i] = 32'h0; end
        pulse_start;
        feed(av, bv, 0, -1, stuck);
        n_cmp++; if (stuck) begin n_bad++; $display("[TB] FAIL b2b_accepts: got stuck=1 expected 0"); end
        wait_done(1'b0, lat, extra, to);
        n_cmp++; if (to || lat != 3) begin n_bad++; $display("[TB] FAIL b2b_latency: got %0d expected 3", lat); end
        n_cmp++; if (sum_out !== 32'h41F00000) begin n_bad++; $display("[TB] FAIL b2b_sum: got %h expected %h", sum_out, 32'h41F00000); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_busy_at_valid: got %b expected 1", busy); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || sum_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_after: got busy=%b valid=%b expected 0/0", busy, sum_valid); end
    endtask

    task automatic test_identical_gapped;
        logic [31:0] av[VLEN], bv[VLEN];
        int lat, extra;
        bit stuck, to;
        for (int i = 0; i < VLEN; i++) begin av[i] = half(1); bv[i] = half(1); end
        pulse_start;
        feed(av, bv, 1, -1, stuck);
        in_valid = 1'b1;
        wait_done(1'b0, lat, extra, to);
        in_valid = 1'b0;
        n_cmp++; if (stuck || to) begin n_bad++; $display("[TB] FAIL ident_progress: got stuck=%b timeout=%b expected 0/0", stuck, to); end
        n_cmp++; if (extra != 0) begin n_bad++; $display("[TB] FAIL ident_extra_accepts: got %0d expected 0", extra); end
        n_cmp++; if (sum_out !== 32'h00000000) begin n_bad++; $display("[TB] FAIL ident_sum: got %h expected %h", sum_out, 32'h0); end
    endtask

    task automatic test_hold;
        logic [31:0] av[VLEN], bv[VLEN];
        int ka[VLEN] = '{4, -4, 4, -4};
        int kb[VLEN] = '{-4, 4, -4, 4};
        int lat, extra;
        bit stuck, to;
        for (int i = 0; i < VLEN; i++) begin av[i] = half(ka[i]); bv[i] = half(kb[i]); end
        pulse_start;
        feed(av, bv, 0, -1, stuck);
        wait_done(1'b0, lat, extra, to);
        n_cmp++; if (to || sum_out !== 32'h42800000) begin n_bad++; $display("[TB] FAIL hold_sum: got %h expected %h", sum_out, 32'h42800000); end
        repeat (5) @(negedge clk);
        n_cmp++; if (sum_out !== 32'h42800000 || sum_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL hold_stable: got %h valid=%b expected %h valid=0", sum_out, sum_valid, 32'h42800000); end
    endtask

    task automatic test_nan;
        logic [31:0] av[VLEN], bv[VLEN];
        int lat, extra;
        bit stuck, to;
        for (int i = 0; i < VLEN; i++) begin av[i] = half(2); bv[i] = 32'h0; end
        bv[1] = 32'h7FC00001;
        pulse_start;
        feed(av, bv, 0, -1, stuck);
        wait_done(1'b0, lat, extra, to);
        n_cmp++; if (to || nan_err !== 1'b1) begin n_bad++; $display("[TB] FAIL nan_flag: got %b expected 1", nan_err); end
        n_cmp++; if (sum_out !== 32'h7FC00000) begin n_bad++; $display("[TB] FAIL nan_sum: got %h expected %h", sum_out, 32'h7FC00000); end
        bv[1] = 32'h0;
        pulse_start;
        @(negedge clk);
        n_cmp++; if (nan_err !== 1'b0) begin n_bad++; $display("[TB] FAIL nan_clear_on_start: got %b expected 0", nan_err); end
        @(posedge clk); #1;
        feed(av, bv, 0, -1, stuck);
        wait_done(1'b0, lat, extra, to);
        n_cmp++; if (to || sum_out !== 32'h40800000 || nan_err !== 1'b0) begin n_bad++; $display("[TB] FAIL nan_next_vector: got %h nan=%b expected %h nan=0", sum_out, nan_err, 32'h40800000); end
    endtask

    task automatic test_async_reset;
        logic [31:0] av[VLEN], bv[VLEN];
        int lat, extra;
        bit stuck, to;
        for (int i = 0; i < VLEN; i++) begin av[i] = half(2); bv[i] = 32'h0; end
        pulse_start;
        in_a = half(2); in_b = 32'h0; in_valid = 1'b1;
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (sum_out !== 32'h0 || sum_valid !== 1'b0 || nan_err !== 1'b0) begin n_bad++; $display("[TB] FAIL areset_outputs: got sum=%h valid=%b nan=%b expected 0", sum_out, sum_valid, nan_err); end
        n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL areset_ctrl: got busy=%b ready=%b expected 0/0", busy, in_ready); end
        in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        pulse_start;
        feed(av, bv, 0, -1, stuck);
        wait_done(1'b0, lat, extra, to);
        n_cmp++; if (to || lat != 3 || sum_out !== 32'h40800000) begin n_bad++; $display("[TB] FAIL areset_restart: got %h lat=%0d expected %h lat=3", sum_out, lat, 32'h40800000); end
    endtask

    task automatic test_start_ignored;
        logic [31:0] av[VLEN], bv[VLEN];
        int ka[VLEN] = '{2, 4, 6, 8};
        int kb[VLEN] = '{2, 0, 2, 0};
        logic [31:0] exp_sum;
        int lat, extra;
        bit stuck, to;
        for (int i = 0; i < VLEN; i++) begin av[i] = half(ka[i]); bv[i] = half(kb[i]); end
        exp_sum = model_sum(ka, kb);
        pulse_start;
        feed(av, bv, 0, 2, stuck);
        wait_done(1'b1, lat, extra, to);
        n_cmp++; if (to || lat != 3) begin n_bad++; $display("[TB] FAIL ign_latency: got %0d expected 3", lat); end
        n_cmp++; if (sum_out !== exp_sum) begin n_bad++; $display("[TB] FAIL ign_sum: got %h expected %h", sum_out, exp_sum); end
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || sum_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL ign_done_start: got busy=%b valid=%b expected 0/0", busy, sum_valid); end
        in_valid = 1'b1;
        in_a = half(6);
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL idle_in_ready: got %b expected 0", in_ready); end
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (busy !== 1'b0 || sum_out !== exp_sum) begin n_bad++; $display("[TB] FAIL idle_no_accept: got busy=%b sum=%h expected 0 %h", busy, sum_out, exp_sum); end
    endtask

    task automatic test_random;
        logic [31:0] av[VLEN], bv[VLEN];
        int ka[VLEN], kb[VLEN];
        logic [31:0] exp_sum;
        int lat, extra;
        bit stuck, to;
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < VLEN; i++) begin
                ka[i] = int'($urandom_range(0, 64)) - 32;
                kb[i] = (v == 3) ? ka[i] : int'($urandom_range(0, 64)) - 32;
                av[i] = half(ka[i]);
                bv[i] = half(kb[i]);
            end
            exp_sum = model_sum(ka, kb);
            pulse_start;
            feed(av, bv, 2, -1, stuck);
            wait_done(1'b0, lat, extra, to);
            n_cmp++; if (stuck || to || lat != 3) begin n_bad++; $display("[TB] FAIL rand%0d_latency: got %0d expected 3", v, lat); end
            n_cmp++; if (sum_out !== exp_sum || nan_err !== 1'b0) begin n_bad++; $display("[TB] FAIL rand%0d_sum: got %h nan=%b expected %h nan=0", v, sum_out, nan_err, exp_sum); end
        end
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_identical_gapped;
        test_hold;
        test_nan;
        test_async_reset;
        test_start_ignored;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
